soc_sw_ctrl: RTL and testbench



---
 rtl/soc_sw_ctrl.sv | 140 ++++++++++++++
 tb/tb_soc_sw_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/soc_sw_ctrl.sv
// Board switch port controller: synchronises and debounces the raw switch
// bus, captures level changes and raises a maskable interrupt. Registers are
// exposed on an Avalon-MM slave with one cycle of read latency.
module soc_sw_ctrl #(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned TICK_DIV     = 50000,
    parameter int unsigned STABLE_TICKS = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_port,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned CW = $clog2(STABLE_TICKS + 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

    logic [WIDTH-1:0] meta;
    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] deb;
    logic [WIDTH-1:0] deb_next;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] edge_cap;
    logic [WIDTH-1:0] edge_clr;
    logic [PW-1:0]    pre;
    logic             tick;
    logic [CW-1:0]    cnt      [WIDTH];
    logic [CW-1:0]    cnt_next [WIDTH];
    logic             wr;
    logic [31:0]      rd_mux;
    logic             unused_wdata;

    assign wr           = chipselect & ~write_n;
    assign tick         = (pre == PRE_LAST);
    assign edge_clr     = (wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
    assign irq          = |(edge_cap & mask);
    assign unused_wdata = ^writedata;

    // Two-flop synchroniser for the asynchronous switch levels.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= '0;
            sync <= '0;
        end else begin
            meta <= in_port;
            sync <= meta;
        end
    end

    // Free-running prescaler producing one debounce sample tick per period.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre <= '0;
        end else if (tick) begin
            pre <= '0;
        end else begin
            pre <= pre + 1'b1;
        end
    end

    // Per-bit debounce: a level is accepted only after STABLE_TICKS ticks of
    // continuous disagreement; any agreement cancels the pending change.
    always_comb begin
        deb_next = deb;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            cnt_next[i] = cnt[i];
            if (sync[i] == deb[i]) begin
                cnt_next[i] = '0;
            end else if (tick) begin
                if (cnt[i] == CNT_LAST) begin
                    deb_next[i] = sync[i];
                    cnt_next[i] = '0;
                end else begin
                    cnt_next[i] = cnt[i] + 1'b1;
                end
            end
        end
    end

    // Debounced level and per-bit stability counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            deb <= '0;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            deb <= deb_next;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                cnt[i] <= cnt_next[i];
            end
        end
    end

    // Interrupt mask register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask <= '0;
        end else if (wr && address == 2'd1) begin
            mask <= writedata[WIDTH-1:0];
        end
    end

    // Edge capture, write-1-to-clear; a same-cycle new edge overrides the clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            edge_cap <= '0;
        end else begin
            edge_cap <= (edge_cap & ~edge_clr) | (deb ^ deb_next);
        end
    end

    // Read mux, zero-extended to the bus width.
    always_comb begin
        rd_mux = '0;
        case (address)
            2'd0:    rd_mux[WIDTH-1:0] = deb;
            2'd1:    rd_mux[WIDTH-1:0] = mask;
            2'd2:    rd_mux[WIDTH-1:0] = sync;
            default: rd_mux[WIDTH-1:0] = edge_cap;
        endcase
    end

    // Registered read data, updated every cycle regardless of chipselect.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata <= '0;
        end else begin
            readdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_soc_sw_ctrl.sv
// Directed bench for soc_sw_ctrl with TICK_DIV=4, STABLE_TICKS=3, WIDTH=8.
module tb_soc_sw_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  in_port;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    soc_sw_ctrl #(
        .WIDTH        (8),
        .TICK_DIV     (4),
        .STABLE_TICKS (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_port    (in_port),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    // Edges since reset release; the prescaler ticks on edges where cyc%4==0.
    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        address = a;
        @(posedge clk);
        #1;
        d = readdata;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic [31:0] exp;
        reset = 1'b1; in_port = 8'hFF; address = 2'd0;
        chipselect = 1'b0; write_n = 1'b1; writedata = '0;
        repeat (3) step();
        vectors++;
        if (readdata !== 32'h0) begin miscompares++; $display("FAIL reset_rd: got %h, required %h", readdata, 32'h0); end
        vectors++;
        if (irq !== 1'b0) begin miscompares++; $display("FAIL reset_irq: got %b, required 0", irq); end
        reset = 1'b0;
        vectors++;
        if (readdata !== 32'h0) begin miscompares++; $display("FAIL release_rd: got %h, required %h", readdata, 32'h0); end
        vectors++;
        if (irq !== 1'b0) begin miscompares++; $display("FAIL release_irq: got %b, required 0", irq); end
        for (int k = 1; k <= 13; k++) begin
            step();
            exp = (k <= 12) ? 32'h0 : 32'hFF;
            vectors++;
            if (readdata !== exp) begin miscompares++; $display("FAIL reset_hold k=%0d: got %h, required %h", k, readdata, exp); end
        end
        vectors++;
        if (irq !== 1'b0) begin miscompares++; $display("FAIL reset_irq_unmasked: got %b, required 0", irq); end
        bus_read(2'd1, d);
        vectors++;
        if (d !== 32'h0) begin miscompares++; $display("FAIL reset_mask: got %h, required %h", d, 32'h0); end
        in_port = 8'h00;
        repeat (20) step();
        bus_write(2'd3, 32'hFF);
        bus_read(2'd3, d);
        vectors++;
        if (d !== 32'h0) begin miscompares++; $display("FAIL reset_edge_clr: got %h, required %h", d, 32'h0); end
        bus_read(2'd0, d);
        vectors++;
        if (d !== 32'h0) begin miscompares++; $display("FAIL reset_deb_back: got %h, required %h", d, 32'h0); end
    endtask

    task automatic test_step();
        logic [31:0] d;
        int seen;
        in_port = 8'h05; address = 2'd2;
        step(); step();
        vectors++;
        if (readdata !== 32'h0) begin miscompares++; $display("FAIL sync_lat2: got %h, required %h", readdata, 32'h0); end
        step();
        vectors++;
        if (readdata !== 32'h05) begin miscompares++; $display("FAIL sync_lat3: got %h, required %h", readdata, 32'h05); end
        address = 2'd0;
        seen = 0;
        for (int k = 4; k <= 30; k++) begin
            step();
            if (seen == 0 && readdata === 32'h05) seen = k;
        end
        vectors++;
        if (seen < 10 || seen > 15) begin miscompares++; $display("FAIL deb_latency: got %0d cycles, required 10..15", seen); end
        bus_read(2'd3, d);
        vectors++;
        if (d !== 32'h05) begin miscompares++; $display("FAIL step_edge: got %h, required %h", d, 32'h05); end
        vectors++;
        if (irq !== 1'b0) begin miscompares++; $display("FAIL step_irq: got %b, required 0", irq); end
        in_port = 8'h00;
        repeat (20) step();
        bus_write(2'd3, 32'hFF);
        bus_read(2'd3, d);
        vectors++;
        if (d !== 32'h0) begin miscompares++; $display("FAIL step_edge_clr: got %h, required %h", d, 32'h0); end
    endtask

    task automatic test_glitch();
        logic [31:0] d;
        in_port = 8'h01;
        repeat (6) step();
        in_port = 8'h00;
        repeat (20) step();
        bus_read(2'd0, d);
        vectors++;
        if (d !== 32'h0) begin miscompares++; $display("FAIL glitch_deb: got %h, required %h", d, 32'h0); end
        bus_read(2'd3, d);
        vectors++;
        if (d !== 32'h0) begin miscompares++; $display("FAIL glitch_edge: got %h, required %h", d, 32'h0); end
        vectors++;
        if (irq !== 1'b0) begin miscompares++; $display("FAIL glitch_irq: got %b, required 0", irq); end
    endtask

    task automatic test_interrupt();
        logic [31:0] d;
        bus_write(2'd1, 32'hFFFF_FF01);
        bus_read(2'd1, d);
        vectors++;
        if (d !== 32'h01) begin miscompares++; $display("FAIL mask_rb: got %h, required %h", d, 32'h01); end
        bus_write(2'd0, 32'hAA);
        bus_read(2'd0, d);
        vectors++;
        if (d !== 32'h0) begin miscompares++; $display("FAIL deb_ro: got %h, required %h", d, 32'h0); end
        in_port = 8'h02;
        repeat (20) step();
        vectors++;
        if (irq !== 1'b0) begin miscompares++; $display("FAIL irq_masked: got %b, required 0", irq); end
        bus_read(2'd3, d);
        vectors++;
        if (d !== 32'h02) begin miscompares++; $display("FAIL edge_bit1: got %h, required %h", d, 32'h02); end
        in_port = 8'h03;
        repeat (20) step();
        vectors++;
        if (irq !== 1'b1) begin miscompares++; $display("FAIL irq_set: got %b, required 1", irq); end
        bus_read(2'd3, d);
        vectors++;
        if (d !== 32'h03) begin miscompares++; $display("FAIL edge_bits01: got %h, required %h", d, 32'h03); end
        bus_write(2'd3, 32'h01);
        vectors++;
        if (irq !== 1'b0) begin miscompares++; $display("FAIL irq_clear: got %b, required 0", irq); end
        bus_read(2'd3, d);
        vectors++;
        if (d !== 32'h02) begin miscompares++; $display("FAIL edge_after_clr: got %h, required %h", d, 32'h02); end
    endtask

    task automatic test_conflict();
        logic [31:0] d;
        while (cyc % 4 != 0) step();
        // deb[0] falls on the third tick edge after the change: 12 edges later.
        in_port = 8'h02;
        repeat (11) step();
        vectors++;
        if (irq !== 1'b0) begin miscompares++; $display("FAIL conflict_pre_irq: got %b, required 0", irq); end
        bus_write(2'd3, 32'h01);
        vectors++;
        if (irq !== 1'b1) begin miscompares++; $display("FAIL conflict_irq: got %b, required 1", irq); end
        bus_read(2'd3, d);
        vectors++;
        if (d !== 32'h03) begin miscompares++; $display("FAIL conflict_edge: got %h, required %h", d, 32'h03); end
        bus_read(2'd0, d);
        vectors++;
        if (d !== 32'h02) begin miscompares++; $display("FAIL conflict_deb: got %h, required %h", d, 32'h02); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        logic [31:0] exp;
        while (cyc % 4 != 0) step();
        in_port = 8'h08;
        repeat (8) step();
        reset = 1'b1;
        step(); step();
        vectors++;
        if (readdata !== 32'h0) begin miscompares++; $display("FAIL midrst_rd: got %h, required %h", readdata, 32'h0); end
        vectors++;
        if (irq !== 1'b0) begin miscompares++; $display("FAIL midrst_irq: got %b, required 0", irq); end
        reset = 1'b0;
        address = 2'd0;
        for (int k = 1; k <= 13; k++) begin
            step();
            exp = (k <= 12) ? 32'h0 : 32'h08;
            vectors++;
            if (readdata !== exp) begin miscompares++; $display("FAIL midrst_hold k=%0d: got %h, required %h", k, readdata, exp); end
        end
        bus_read(2'd1, d);
        vectors++;
        if (d !== 32'h0) begin miscompares++; $display("FAIL midrst_mask: got %h, required %h", d, 32'h0); end
        bus_read(2'd3, d);
        vectors++;
        if (d !== 32'h08) begin miscompares++; $display("FAIL midrst_edge: got %h, required %h", d, 32'h08); end
    endtask

    initial begin
        test_reset();
        test_step();
        test_glitch();
        test_interrupt();
        test_conflict();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded 100000 time units");
        $fatal(1);
    end

endmodule
